// File: rtl/ethpipe_pkg.sv
// ethpipe_pkg: shared TX state encoding, framing bytes and CRC-32 constants
package ethpipe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    // Bit-reverse a word; the LSB-first CRC shifts against the reflected polynomial
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/ethpipe_crc32_d8.sv
// crc32_d8: combinational reflected CRC-32 update for one byte, LSB first
module crc32_d8
    import ethpipe_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

    // Eight serial shift steps unrolled into one combinational update
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++)
            crc_out = {1'b0, crc_out[31:1]} ^ ((crc_out[0] ^ d[i]) ? POLY_R : 32'h0);
    end

endmodule

// File: rtl/ethpipe_tx.sv
// ethpipe_tx: GMII transmitter reading a 16-bit TX slot, adding padding, FCS and IFG
module ethpipe_tx
    import ethpipe_pkg::*;
#(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_FRAME  = 60
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] global_counter,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic [11:0] slot_tx_eth_address,
    input  logic [15:0] slot_tx_eth_q,
    input  logic [11:0] tx_frame_len,
    input  logic        tx_start,
    output logic        tx_busy,
    output logic        tx_complete,
    output logic [31:0] tx_timestamp
);

    tx_state_t   r_state;
    logic [11:0] r_len;
    logic [11:0] r_cnt;
    logic [7:0]  r_sub;
    logic [7:0]  r_hi;
    logic [31:0] r_crc;

    logic [7:0]  w_byte;
    logic [7:0]  w_din;
    logic [31:0] w_crc_next;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;
    logic        w_data_last;
    logic        w_more;
    logic        w_short;
    logic        w_pad_last;

    // Even bytes come straight from the slot word, odd bytes from the held high half
    assign w_byte      = r_cnt[0] ? r_hi : slot_tx_eth_q[7:0];
    assign w_din       = (r_state == ST_DATA) ? w_byte : 8'h00;
    assign w_fcs       = ~r_crc;
    assign w_fcs_byte  = 8'(w_fcs >> {r_sub[1:0], 3'b000});
    assign w_data_last = r_cnt == r_len - 12'd1;
    assign w_more      = {1'b0, r_cnt} + 13'd2 < {1'b0, r_len};
    assign w_short     = r_len < 12'(MIN_FRAME);
    assign w_pad_last  = {4'b0, r_sub} + r_len == 12'(MIN_FRAME - 1);

    crc32_d8 u_crc (
        .crc_in  (r_crc),
        .d       (w_din),
        .crc_out (w_crc_next)
    );

    // Frame sequencer; the slot address advances when a word's low byte is taken,
    // so the next word has settled by the following even byte
    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n) begin
            r_state             <= ST_IDLE;
            r_len               <= '0;
            r_cnt               <= '0;
            r_sub               <= '0;
            r_hi                <= '0;
            r_crc               <= CRC32_INIT;
            gmii_txd            <= '0;
            gmii_tx_en          <= 1'b0;
            slot_tx_eth_address <= '0;
            tx_busy             <= 1'b0;
            tx_complete         <= 1'b0;
            tx_timestamp        <= '0;
        end else begin
            tx_complete <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= '0;
                    if (tx_start && tx_frame_len != 12'd0) begin
                        r_len               <= tx_frame_len;
                        r_sub               <= '0;
                        tx_busy             <= 1'b1;
                        slot_tx_eth_address <= '0;
                        r_state             <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= PREAMBLE_BYTE;
                    r_sub      <= r_sub + 8'd1;
                    if (r_sub == 8'd6) r_state <= ST_SFD;
                end
                ST_SFD: begin
                    gmii_txd     <= SFD_BYTE;
                    tx_timestamp <= global_counter;
                    r_crc        <= CRC32_INIT;
                    r_cnt        <= '0;
                    r_sub        <= '0;
                    r_state      <= ST_DATA;
                end
                ST_DATA: begin
                    gmii_txd <= w_byte;
                    r_crc    <= w_crc_next;
                    r_cnt    <= r_cnt + 12'd1;
                    if (!r_cnt[0]) begin
                        r_hi <= slot_tx_eth_q[15:8];
                        if (w_more) slot_tx_eth_address <= slot_tx_eth_address + 12'd1;
                    end
                    if (w_data_last) r_state <= w_short ? ST_PAD : ST_FCS;
                end
                ST_PAD: begin
                    gmii_txd <= '0;
                    r_crc    <= w_crc_next;
                    r_sub    <= w_pad_last ? 8'd0 : r_sub + 8'd1;
                    if (w_pad_last) r_state <= ST_FCS;
                end
                ST_FCS: begin
                    gmii_txd <= w_fcs_byte;
                    r_sub    <= (r_sub == 8'd3) ? 8'd0 : r_sub + 8'd1;
                    if (r_sub == 8'd3) r_state <= ST_IFG;
                end
                ST_IFG: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= '0;
                    r_sub      <= r_sub + 8'd1;
                    if (r_sub == 8'(IFG_CYCLES - 1)) begin
                        tx_complete <= 1'b1;
                        tx_busy     <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ethpipe_tx.sv
// tb_ethpipe_tx: directed and randomized frame checks against a byte-level reference model
module tb_ethpipe_tx;

    localparam int IFG  = 12;
    localparam int MINF = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gc = 32'hA5A5_0000;
    logic [7:0]  txd;
    logic        tx_en;
    logic [11:0] addr;
    logic [15:0] q = '0;
    logic [11:0] len = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        complete;
    logic [31:0] ts;

    logic [15:0] mem [0:4095];
    logic [7:0]  img[$];
    logic [7:0]  cap[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          wait_n;
    int          gap;
    int          max_addr;
    logic [31:0] ts_exp = '0;
    bit          ifg_ok;

    ethpipe_tx dut (
        .gmii_tx_clk         (clk),
        .sys_rst_n           (rst_n),
        .global_counter      (gc),
        .gmii_txd            (txd),
        .gmii_tx_en          (tx_en),
        .slot_tx_eth_address (addr),
        .slot_tx_eth_q       (q),
        .tx_frame_len        (len),
        .tx_start            (start),
        .tx_busy             (busy),
        .tx_complete         (complete),
        .tx_timestamp        (ts)
    );

    always #4 clk = ~clk;

    always @(posedge clk) begin
        gc <= gc + 32'd1;
        q  <= mem[addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Textbook MSB-first CRC-32 with each byte fed LSB first, result reflected and inverted
    function automatic logic [31:0] ref_fcs(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [31:0] r;
        logic        fb;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ img[i][b];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C11DB7;
            end
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        return ~r;
    endfunction

    task automatic fill(input int L, input bit idx);
        logic [7:0] b;
        img.delete();
        for (int w = 0; w <= L / 2 && w < 4096; w++) mem[w] = 16'($urandom);
        for (int i = 0; i < L; i++) begin
            b = idx ? 8'(i) : 8'($urandom);
            img.push_back(b);
            mem[i/2][(i%2)*8 +: 8] = b;
        end
        for (int i = L; i < MINF; i++) img.push_back(8'h00);
    endtask

    task automatic start_frame(input int L);
        @(negedge clk);
        len   = 12'(L);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        len   = 12'($urandom_range(1, 4095));
    endtask

    task automatic capture();
        int n = 0;
        cap.delete();
        max_addr = 0;
        wait_n   = 0;
        ifg_ok   = 1'b1;
        while (!tx_en && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        if (!tx_en) begin
            chk("tx_en_rise", 32'(tx_en), 32'd1);
            return;
        end
        while (tx_en && n < 5000) begin
            cap.push_back(txd);
            if (cap.size() == 8) ts_exp = gc - 32'd1;
            if (int'(addr) > max_addr) max_addr = int'(addr);
            @(negedge clk);
            n++;
        end
        gap = 1;
        while (!complete && gap < 100) begin
            @(negedge clk);
            gap++;
            if (tx_en) ifg_ok = 1'b0;
        end
    endtask

    task automatic check_frame(input int L);
        int total = 8 + (L > MINF ? L : MINF) + 4;
        int bad = 0;
        logic [31:0] fcs;
        chk("tx_en_cycles", cap.size(), total);
        if (cap.size() == total) begin
            for (int i = 0; i < 7; i++) bad += int'(cap[i] != 8'h55);
            bad += int'(cap[7] != 8'hD5);
            chk("preamble_sfd", bad, 0);
            bad = 0;
            for (int i = 0; i < img.size(); i++) bad += int'(cap[8+i] != img[i]);
            chk("data_pad_bytes", bad, 0);
            fcs = {cap[total-1], cap[total-2], cap[total-3], cap[total-4]};
            chk("fcs", fcs, ref_fcs(img.size()));
        end
        chk("timestamp", ts, ts_exp);
        chk("complete_cycle", gap, IFG);
        chk("ifg_quiet", 32'(ifg_ok), 32'd1);
        chk("busy_at_complete", 32'(busy), 32'd0);
        chk("last_addr", max_addr, (L - 1) / 2);
    endtask

    initial begin
        int L;
        int cnt;
        for (int w = 0; w < 4096; w++) mem[w] = '0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {tx_en, busy, complete, txd, addr}, 32'd0);
        end
        chk("reset_timestamp", ts, 32'd0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_outputs", {tx_en, busy, txd}, 32'd0);
        end

        fill(60, 1'b1);
        start_frame(60);
        capture();
        check_frame(60);

        fill(14, 1'b0);
        start_frame(14);
        capture();
        check_frame(14);

        fill(1, 1'b0);
        start_frame(1);
        capture();
        check_frame(1);

        fill(1515, 1'b0);
        start_frame(1515);
        capture();
        check_frame(1515);

        repeat (3) begin
            L = $urandom_range(2, 200);
            fill(L, 1'b0);
            start_frame(L);
            capture();
            check_frame(L);
        end

        @(negedge clk);
        len   = 12'd0;
        start = 1'b1;
        repeat (20) @(negedge clk);
        chk("len0_ignored", {busy, tx_en}, 32'd0);
        fill(64, 1'b0);
        len = 12'd64;
        capture();
        check_frame(64);
        @(negedge clk);
        chk("b2b_accept", 32'(busy), 32'd1);
        start = 1'b0;
        capture();
        chk("b2b_wait", wait_n, 1);
        check_frame(64);

        fill(40, 1'b0);
        start_frame(40);
        cnt = 0;
        while (!tx_en && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        repeat (28) @(negedge clk);
        chk("mid_reset_byte20", txd, img[20]);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", {tx_en, busy, txd}, 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            cnt += int'(complete) + int'(tx_en);
        end
        chk("mid_reset_quiet", cnt, 0);
        fill(61, 1'b0);
        start_frame(61);
        capture();
        check_frame(61);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
